audio_sample_sched: RTL and testbench

Sample-rate scheduler and source controller for the audio datapath. It derives the per-sample strobe from MCLK and selects, per sample, one of three sources: the external codec word, the sine-table ROM, or mute. For ROM samples it sequences the ROM address and clock. It presents each sample to the downstream serializer through a one-entry valid/ready holding register.

---
 rtl/audio_sample_sched.sv | 180 ++++++++++++++++++
 tb/tb_audio_sample_sched.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_sample_sched.sv
// Sample-rate scheduler and source controller: derives the per-sample strobe from MCLK,
// picks codec / sine-ROM / mute per sample and presents it through a one-entry holding register.
module audio_sample_sched #(
  parameter int unsigned DIV     = 256,
  parameter int unsigned ROM_LEN = 194,
  parameter int unsigned ROM_LAT = 2
) (
  input  logic        MCLK,
  input  logic        RESET,
  input  logic        EN,
  input  logic [1:0]  SRC_SEL,
  input  logic [15:0] EXT_DATA16,
  input  logic [15:0] ROM_Q,
  input  logic        CLR_OVR,
  output logic [7:0]  ROM_ADDR,
  output logic        ROM_CK,
  output logic        SAMPLE_TR,
  output logic [15:0] OUT_DATA16,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic        OVERRUN,
  output logic [2:0]  ST
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned SRC_W  = 2;
  localparam int unsigned CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned LAT_W  = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  localparam logic [SRC_W-1:0] SRC_EXT = SRC_W'(0);
  localparam logic [SRC_W-1:0] SRC_ROM = SRC_W'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT     = 3'd1,
    S_ROM_REQ  = 3'd2,
    S_ROM_WAIT = 3'd3,
    S_CAPTURE  = 3'd4
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   tick_cnt;
  logic [LAT_W-1:0]   lat_cnt;
  logic [LAT_W-1:0]   lat_cnt_nxt;
  logic [SRC_W-1:0]   src_q;
  logic [SRC_W-1:0]   src_nxt;
  logic               cap_c;
  logic               ovr_set_c;
  logic [DATA_W-1:0]  cap_data_c;
  logic [ADDR_W-1:0]  addr_inc_c;

  // Sample-period divider; strobe is high the cycle after the counter hits DIV-1
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      tick_cnt  <= '0;
      SAMPLE_TR <= 1'b0;
    end else if (!EN) begin
      tick_cnt  <= '0;
      SAMPLE_TR <= 1'b0;
    end else if (tick_cnt == CNT_W'(DIV - 1)) begin
      tick_cnt  <= '0;
      SAMPLE_TR <= 1'b1;
    end else begin
      tick_cnt  <= tick_cnt + CNT_W'(1);
      SAMPLE_TR <= 1'b0;
    end
  end

  // State register
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      state   <= S_IDLE;
      lat_cnt <= '0;
      src_q   <= SRC_EXT;
    end else begin
      state   <= state_nxt;
      lat_cnt <= lat_cnt_nxt;
      src_q   <= src_nxt;
    end
  end

  // Next-state: dropping EN abandons any in-flight sample
  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    src_nxt     = src_q;
    if (!EN) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: state_nxt = S_WAIT;
        S_WAIT: begin
          if (SAMPLE_TR) begin
            src_nxt = SRC_SEL;
            if (SRC_SEL == SRC_ROM) begin
              state_nxt = S_ROM_REQ;
            end else begin
              state_nxt = S_CAPTURE;
            end
          end
        end
        S_ROM_REQ: begin
          state_nxt   = S_ROM_WAIT;
          lat_cnt_nxt = '0;
        end
        S_ROM_WAIT: begin
          if (lat_cnt == LAT_W'(ROM_LAT - 1)) begin
            state_nxt = S_CAPTURE;
          end else begin
            lat_cnt_nxt = lat_cnt + LAT_W'(1);
          end
        end
        S_CAPTURE: state_nxt = S_WAIT;
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  assign ST = state;

  // Capture strobe and selected sample word
  always_comb begin
    cap_c      = (state == S_CAPTURE) && EN;
    cap_data_c = '0;
    if (src_q == SRC_EXT) begin
      cap_data_c = EXT_DATA16;
    end else if (src_q == SRC_ROM) begin
      cap_data_c = ROM_Q;
    end
    addr_inc_c = (ROM_ADDR == ADDR_W'(ROM_LEN - 1)) ? '0 : ROM_ADDR + ADDR_W'(1);
    ovr_set_c  = (cap_c && OUT_VALID && !OUT_READY) || (SAMPLE_TR && (state != S_WAIT));
  end

  // ROM read clock is high exactly while in ROM_REQ
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      ROM_CK <= 1'b0;
    end else begin
      ROM_CK <= (state_nxt == S_ROM_REQ);
    end
  end

  // ROM address advances only when a ROM sample reaches capture
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      ROM_ADDR <= '0;
    end else if (cap_c && (src_q == SRC_ROM)) begin
      ROM_ADDR <= addr_inc_c;
    end
  end

  // One-entry holding register; a full register with no ready drops the new sample
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      OUT_DATA16 <= '0;
      OUT_VALID  <= 1'b0;
    end else if (cap_c) begin
      if (!OUT_VALID || OUT_READY) begin
        OUT_DATA16 <= cap_data_c;
        OUT_VALID  <= 1'b1;
      end
    end else if (OUT_VALID && OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

  // Sticky overrun; a set event beats a simultaneous clear
  always_ff @(posedge MCLK) begin
    if (RESET) begin
      OVERRUN <= 1'b0;
    end else if (ovr_set_c) begin
      OVERRUN <= 1'b1;
    end else if (CLR_OVR) begin
      OVERRUN <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_sample_sched.sv
// Randomised scoreboard bench for audio_sample_sched against a timing-level reference model.
module tb_audio_sample_sched;

  localparam int unsigned DIV_T     = 16;
  localparam int unsigned ROM_LEN_T = 194;
  localparam int unsigned ROM_LAT_T = 2;

  logic        MCLK;
  logic        RESET;
  logic        EN;
  logic [1:0]  SRC_SEL;
  logic [15:0] EXT_DATA16;
  logic [15:0] ROM_Q;
  logic        CLR_OVR;
  logic [7:0]  ROM_ADDR;
  logic        ROM_CK;
  logic        SAMPLE_TR;
  logic [15:0] OUT_DATA16;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic        OVERRUN;
  logic [2:0]  ST;

  audio_sample_sched #(.DIV(DIV_T), .ROM_LEN(ROM_LEN_T), .ROM_LAT(ROM_LAT_T)) dut (
    .MCLK(MCLK), .RESET(RESET), .EN(EN), .SRC_SEL(SRC_SEL), .EXT_DATA16(EXT_DATA16),
    .ROM_Q(ROM_Q), .CLR_OVR(CLR_OVR), .ROM_ADDR(ROM_ADDR), .ROM_CK(ROM_CK),
    .SAMPLE_TR(SAMPLE_TR), .OUT_DATA16(OUT_DATA16), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OVERRUN(OVERRUN), .ST(ST)
  );

  initial begin
    MCLK = 1'b0;
    forever #5 MCLK = ~MCLK;
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Sine-ROM model: data for the clocked address appears ROM_LAT cycles after ROM_CK falls
  int          rom_cnt = 0;
  logic [7:0]  rom_lat_addr = 8'd0;
  initial ROM_Q = 16'hDEAD;
  always @(posedge MCLK) begin
    if (ROM_CK) begin
      rom_cnt      <= ROM_LAT_T;
      rom_lat_addr <= ROM_ADDR;
      ROM_Q        <= 16'hDEAD;
    end else if (rom_cnt > 1) begin
      rom_cnt <= rom_cnt - 1;
    end else if (rom_cnt == 1) begin
      ROM_Q   <= 16'h0100 + {8'h00, rom_lat_addr};
      rom_cnt <= 0;
    end
  end

  // Reference model: expected values for the cycle after each edge, from the sample timing rules
  logic [15:0] exp_q[$];
  int          n_en   = 0;
  int          cap_at = -1;
  logic [1:0]  m_src  = 2'd0;
  logic        m_tr = 1'b0, m_ck = 1'b0, m_valid = 1'b0, m_ovr = 1'b0, m_idle = 1'b1;
  logic [15:0] m_data = 16'h0;
  logic [7:0]  m_addr = 8'h0;
  logic        rdy_edge = 1'b0;

  always @(posedge MCLK) begin : ref_model
    logic nxt_tr, nxt_ck, ovr_set;
    logic [15:0] d;
    rdy_edge = OUT_READY;
    if (RESET) begin
      n_en = 0; cap_at = -1; m_src = 2'd0;
      m_tr = 1'b0; m_ck = 1'b0; m_valid = 1'b0; m_ovr = 1'b0; m_idle = 1'b1;
      m_data = 16'h0; m_addr = 8'h0;
    end else begin
      nxt_tr = 1'b0; nxt_ck = 1'b0; ovr_set = 1'b0;
      if (!EN) begin
        n_en = 0;
        cap_at = -1;
      end else begin
        n_en++;
        nxt_tr = (n_en % DIV_T == 0);
        if (m_tr) begin
          if (cap_at >= 0) begin
            ovr_set = 1'b1;
          end else begin
            m_src = SRC_SEL;
            if (SRC_SEL == 2'd1) begin
              nxt_ck = 1'b1;
              cap_at = cyc + 2 + ROM_LAT_T;
            end else begin
              cap_at = cyc + 1;
            end
          end
        end
      end
      if (EN && cap_at == cyc) begin
        if (m_src == 2'd0) d = EXT_DATA16;
        else if (m_src == 2'd1) d = 16'h0100 + {8'h00, m_addr};
        else d = 16'h0000;
        if (!m_valid || OUT_READY) begin
          m_valid = 1'b1;
          m_data  = d;
          exp_q.push_back(d);
        end else begin
          ovr_set = 1'b1;
        end
        if (m_src == 2'd1) m_addr = (m_addr == 8'(ROM_LEN_T - 1)) ? 8'd0 : m_addr + 8'd1;
        cap_at = -1;
      end else if (m_valid && OUT_READY) begin
        m_valid = 1'b0;
      end
      if (ovr_set) m_ovr = 1'b1;
      else if (CLR_OVR) m_ovr = 1'b0;
      m_tr = nxt_tr;
      m_ck = nxt_ck;
      m_idle = !EN;
    end
    cyc++;
  end

  // Monitor: per-cycle output checks plus scoreboard pop whenever a new sample is presented
  logic v_prev = 1'b0;
  always @(posedge MCLK) begin : monitor
    logic [15:0] e;
    #1;
    chk("sample_tr", 16'(SAMPLE_TR), 16'(m_tr));
    chk("rom_ck", 16'(ROM_CK), 16'(m_ck));
    chk("rom_addr", 16'(ROM_ADDR), 16'(m_addr));
    chk("out_valid", 16'(OUT_VALID), 16'(m_valid));
    chk("out_data_hold", OUT_DATA16, m_data);
    chk("overrun", 16'(OVERRUN), 16'(m_ovr));
    if (m_idle) chk("st_idle", 16'(ST), 16'd0);
    if (OUT_VALID && (!v_prev || rdy_edge)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: actual=%h expected=none (cycle %0d)", OUT_DATA16, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", OUT_DATA16, e);
      end
    end
    v_prev = OUT_VALID;
  end

  task automatic step(input int n);
    repeat (n) @(negedge MCLK);
  endtask

  task automatic wait_tick();
    bit hit = 1'b0;
    for (int i = 0; i < 3 * DIV_T && !hit; i++) begin
      @(posedge MCLK);
      #1;
      hit = SAMPLE_TR;
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL wait_tick: actual=no_strobe expected=strobe within %0d cycles", 3 * DIV_T);
    end
  endtask

  task automatic wait_st(input logic [2:0] s);
    bit hit = 1'b0;
    for (int i = 0; i < 3 * DIV_T && !hit; i++) begin
      @(posedge MCLK);
      #1;
      hit = (ST == s);
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL wait_st: actual=%0d expected=%0d", ST, s);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; EN = 1'b0; SRC_SEL = 2'd0; EXT_DATA16 = 16'h0;
    CLR_OVR = 1'b0; OUT_READY = 1'b0;
    step(3);
    chk("rst_st", 16'(ST), 16'd0);
    chk("rst_valid", 16'(OUT_VALID), 16'd0);
    chk("rst_addr", 16'(ROM_ADDR), 16'd0);

    // Ext source, always ready
    RESET = 1'b0; EN = 1'b1; SRC_SEL = 2'd0; EXT_DATA16 = 16'h1234; OUT_READY = 1'b1;
    step(3 * DIV_T + 4);
    chk("ext_addr", 16'(ROM_ADDR), 16'd0);

    // ROM source, through the table wrap
    SRC_SEL = 2'd1;
    step(199 * DIV_T);

    // Mute
    SRC_SEL = 2'd2; EXT_DATA16 = 16'hFFFF;
    step(2 * DIV_T);

    // Overrun: two captures with no ready, then a handshake exactly at the capture edge
    SRC_SEL = 2'd0;
    wait_tick();
    step(4);
    OUT_READY = 1'b0; EXT_DATA16 = 16'hAAAA;
    wait_tick();
    step(3);
    EXT_DATA16 = 16'h5555;
    wait_tick();
    step(3);
    chk("ovr_hold_data", OUT_DATA16, 16'hAAAA);
    chk("ovr_set", 16'(OVERRUN), 16'd1);
    CLR_OVR = 1'b1;
    step(1);
    CLR_OVR = 1'b0;
    chk("ovr_clr", 16'(OVERRUN), 16'd0);
    EXT_DATA16 = 16'h3C3C;
    wait_tick();
    @(negedge MCLK);
    @(negedge MCLK);
    OUT_READY = 1'b1;
    @(negedge MCLK);
    OUT_READY = 1'b0;
    chk("hs_cap_valid", 16'(OUT_VALID), 16'd1);
    chk("hs_cap_data", OUT_DATA16, 16'h3C3C);
    chk("hs_cap_ovr", 16'(OVERRUN), 16'd0);
    OUT_READY = 1'b1;
    step(2);

    // Reset during ROM_WAIT
    SRC_SEL = 2'd1;
    wait_tick();
    wait_st(3'd3);
    @(negedge MCLK);
    RESET = 1'b1;
    @(negedge MCLK);
    chk("rr_st", 16'(ST), 16'd0);
    chk("rr_addr", 16'(ROM_ADDR), 16'd0);
    chk("rr_ck", 16'(ROM_CK), 16'd0);
    chk("rr_tr", 16'(SAMPLE_TR), 16'd0);
    chk("rr_valid", 16'(OUT_VALID), 16'd0);
    chk("rr_data", OUT_DATA16, 16'd0);
    chk("rr_ovr", 16'(OVERRUN), 16'd0);
    RESET = 1'b0;

    // EN drop during ROM_WAIT with a held sample
    wait_tick();
    @(negedge MCLK);
    OUT_READY = 1'b0;
    wait_tick();
    wait_st(3'd3);
    @(negedge MCLK);
    EN = 1'b0;
    @(negedge MCLK);
    chk("en0_st", 16'(ST), 16'd0);
    chk("en0_addr", 16'(ROM_ADDR), 16'd1);
    chk("en0_valid", 16'(OUT_VALID), 16'd1);
    chk("en0_data", OUT_DATA16, 16'h0100);
    step(3);
    chk("en0_keep_valid", 16'(OUT_VALID), 16'd1);
    OUT_READY = 1'b1;
    step(2);
    chk("en0_drain_valid", 16'(OUT_VALID), 16'd0);
    chk("en0_drain_data", OUT_DATA16, 16'h0100);

    // Random traffic
    EN = 1'b1;
    for (int i = 0; i < 1600; i++) begin
      @(negedge MCLK);
      SRC_SEL    = 2'($urandom_range(0, 3));
      EXT_DATA16 = 16'($urandom);
      OUT_READY  = ($urandom_range(0, 3) != 0);
      CLR_OVR    = ($urandom_range(0, 40) == 0);
      EN         = ($urandom_range(0, 200) != 0);
    end

    EN = 1'b1; CLR_OVR = 1'b0; OUT_READY = 1'b1;
    step(40);
    chk("sb_empty", 16'(exp_q.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
